// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with iterative shift-add multiplier and restoring divider
// Optional build macro HILO_FWD_EN forwards MTHI/MTLO data and the FIN result combinationally onto hi_o/lo_o.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi, r_lo, r_a, r_b;
  logic [2*WIDTH-1:0] r_prod;
  logic               r_neg, r_dneg, r_is_div, r_zero;
  logic               r_busy, r_done, r_dbz;

  logic             w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic             w_is_mul, w_is_div, w_is_mthi, w_is_mtlo, w_last;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0] w_quo, w_rem, w_fin_hi, w_fin_lo;

  assign w_signed  = ~op[0];
  assign w_a_neg   = w_signed & src_a[WIDTH-1];
  assign w_b_neg   = w_signed & src_b[WIDTH-1];
  assign w_mag_a   = w_a_neg ? -src_a : src_a;
  assign w_mag_b   = w_b_neg ? -src_b : src_b;
  assign w_is_mul  = (op[2:1] == 2'b00);
  assign w_is_div  = (op[2:1] == 2'b01);
  assign w_is_mthi = (op == 3'b100);
  assign w_is_mtlo = (op == 3'b101);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // r_prod holds {partial product, remaining multiplier} during MUL and {remainder, dividend/quotient} during DIV
  assign w_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_a : {WIDTH{1'b0}})};
  assign w_diff = r_prod[2*WIDTH-1:WIDTH-1] - {1'b0, r_b};

  assign w_prod_s = r_neg  ? -r_prod : r_prod;
  assign w_quo    = r_neg  ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
  assign w_rem    = r_dneg ? -r_prod[2*WIDTH-1:WIDTH] : r_prod[2*WIDTH-1:WIDTH];
  assign w_fin_hi = r_is_div ? w_rem : w_prod_s[2*WIDTH-1:WIDTH];
  assign w_fin_lo = r_is_div ? w_quo : w_prod_s[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_neg    <= 1'b0;
      r_dneg   <= 1'b0;
      r_is_div <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_is_mthi) begin
              r_hi <= src_a;
            end else if (w_is_mtlo) begin
              r_lo <= src_a;
            end else if (w_is_mul) begin
              r_a      <= w_mag_a;
              r_b      <= w_mag_b;
              r_prod   <= {{WIDTH{1'b0}}, w_mag_b};
              r_neg    <= w_a_neg ^ w_b_neg;
              r_dneg   <= 1'b0;
              r_is_div <= 1'b0;
              r_zero   <= 1'b0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end else if (w_is_div) begin
              r_b      <= w_mag_b;
              r_prod   <= {{WIDTH{1'b0}}, w_mag_a};
              r_neg    <= w_a_neg ^ w_b_neg;
              r_dneg   <= w_a_neg;
              r_is_div <= 1'b1;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_zero   <= (src_b == '0);
              r_state  <= (src_b == '0) ? S_FIN : S_DIV;
            end
          end
        end
        S_MUL: begin
          r_prod <= {w_sum, r_prod[WIDTH-1:1]};
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIN;
        end
        S_DIV: begin
          if (!w_diff[WIDTH]) r_prod <= {w_diff[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};
          else                r_prod <= {r_prod[2*WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= S_FIN;
        end
        S_FIN: begin
          if (!r_zero) begin
            r_hi <= w_fin_hi;
            r_lo <= w_fin_lo;
          end
          r_done  <= 1'b1;
          r_dbz   <= r_zero;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

`ifdef HILO_FWD_EN
  always_comb begin
    hi_o = r_hi;
    lo_o = r_lo;
    if (r_state == S_FIN && !r_zero) begin
      hi_o = w_fin_hi;
      lo_o = w_fin_lo;
    end else if (r_state == S_IDLE && start) begin
      if (w_is_mthi) hi_o = src_a;
      if (w_is_mtlo) lo_o = src_a;
    end
  end
`else
  assign hi_o = r_hi;
  assign lo_o = r_lo;
`endif

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;
  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi_o, lo_o;

  int n_pass = 0;
  int n_total = 0;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1 n++;
      if (done) return;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (hi_o !== 32'h0) $display("FAIL reset_hi got %h exp 0", hi_o); else n_pass++;
    n_total++; if (lo_o !== 32'h0) $display("FAIL reset_lo got %h exp 0", lo_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b exp 0", div_by_zero); else n_pass++;
  endtask

  task automatic test_move;
    issue(OP_MTHI, 32'h0000_5555, 32'h0);
    n_total++; if (hi_o !== 32'h0000_5555) $display("FAIL mthi got %h exp 00005555", hi_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mthi_busy got %b exp 0", busy); else n_pass++;
    issue(OP_MTLO, 32'h0000_AAAA, 32'h0);
    n_total++; if (lo_o !== 32'h0000_AAAA) $display("FAIL mtlo got %h exp 0000aaaa", lo_o); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mtlo_done got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_mult_signed;
    int n;
    logic held;
    held = 1'b1;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1 n++;
      if (done) break;
      if (busy !== 1'b1 || hi_o !== 32'h0000_5555 || lo_o !== 32'h0000_AAAA) held = 1'b0;
    end
    n_total++; if (n !== 33) $display("FAIL mult_latency got %0d exp 33", n); else n_pass++;
    n_total++; if (held !== 1'b1) $display("FAIL mult_hold got %b exp 1", held); else n_pass++;
    n_total++; if (hi_o !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h exp ffffffff", hi_o); else n_pass++;
    n_total++; if (lo_o !== 32'hFFFF_FFF1) $display("FAIL mult_lo got %h exp fffffff1", lo_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL mult_busy_at_done got %b exp 0", busy); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (done !== 1'b0) $display("FAIL mult_done_pulse got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_mult_unsigned;
    int n;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n);
    n_total++; if (hi_o !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h exp fffffffe", hi_o); else n_pass++;
    n_total++; if (lo_o !== 32'h0000_0001) $display("FAIL multu_lo got %h exp 00000001", lo_o); else n_pass++;
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    n_total++; if (hi_o !== 32'h4000_0000) $display("FAIL mult_min_hi got %h exp 40000000", hi_o); else n_pass++;
    n_total++; if (lo_o !== 32'h0000_0000) $display("FAIL mult_min_lo got %h exp 00000000", lo_o); else n_pass++;
  endtask

  task automatic test_div;
    int n;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    n_total++; if (n !== 33) $display("FAIL div_latency got %0d exp 33", n); else n_pass++;
    n_total++; if (lo_o !== 32'hFFFF_FFFD) $display("FAIL div_quo got %h exp fffffffd", lo_o); else n_pass++;
    n_total++; if (hi_o !== 32'hFFFF_FFFF) $display("FAIL div_rem got %h exp ffffffff", hi_o); else n_pass++;
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    n_total++; if (lo_o !== 32'h8000_0000) $display("FAIL div_ovf_quo got %h exp 80000000", lo_o); else n_pass++;
    n_total++; if (hi_o !== 32'h0000_0000) $display("FAIL div_ovf_rem got %h exp 00000000", hi_o); else n_pass++;
    n_total++; if (div_by_zero !== 1'b0) $display("FAIL div_ovf_dbz got %b exp 0", div_by_zero); else n_pass++;
  endtask

  task automatic test_div_zero;
    int n;
    issue(OP_MTHI, 32'h11, 32'h0);
    issue(OP_MTLO, 32'h22, 32'h0);
    issue(OP_DIVU, 32'd99, 32'h0);
    n_total++; if (busy !== 1'b1) $display("FAIL dbz_busy got %b exp 1", busy); else n_pass++;
    wait_done(n);
    n_total++; if (n !== 1) $display("FAIL dbz_latency got %0d exp 1", n); else n_pass++;
    n_total++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag got %b exp 1", div_by_zero); else n_pass++;
    n_total++; if (hi_o !== 32'h11) $display("FAIL dbz_hi got %h exp 00000011", hi_o); else n_pass++;
    n_total++; if (lo_o !== 32'h22) $display("FAIL dbz_lo got %h exp 00000022", lo_o); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL dbz_busy_at_done got %b exp 0", busy); else n_pass++;
    @(posedge clk);
    #1;
    n_total++; if (div_by_zero !== 1'b0) $display("FAIL dbz_pulse got %b exp 0", div_by_zero); else n_pass++;
  endtask

  task automatic test_abort;
    logic seen_done;
    seen_done = 1'b0;
    issue(OP_MTHI, 32'h0000_5555, 32'h0);
    issue(OP_MULTU, 32'd1000, 32'd1000);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 5) begin start = 1'b1; op = OP_MTHI; src_a = 32'h0000_ABCD; end
      if (i == 10) rst = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      rst = 1'b0;
      if (done) seen_done = 1'b1;
      if (i == 5) begin
        n_total++; if (hi_o !== 32'h0000_5555) $display("FAIL busy_mthi_ignored got %h exp 00005555", hi_o); else n_pass++;
      end
    end
    n_total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy); else n_pass++;
    n_total++; if (hi_o !== 32'h0) $display("FAIL abort_hi got %h exp 0", hi_o); else n_pass++;
    n_total++; if (lo_o !== 32'h0) $display("FAIL abort_lo got %h exp 0", lo_o); else n_pass++;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) seen_done = 1'b1;
    end
    n_total++; if (seen_done !== 1'b0) $display("FAIL abort_no_done got %b exp 0", seen_done); else n_pass++;
    issue(OP_MTLO, 32'h0000_1234, 32'h0);
    n_total++; if (lo_o !== 32'h0000_1234) $display("FAIL abort_mtlo got %h exp 00001234", lo_o); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL abort_mtlo_done got %b exp 0", done); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(n);
    n_total++; if (done !== 1'b1) $display("FAIL b2b_first_done got %b exp 1", done); else n_pass++;
    n_total++; if (lo_o !== 32'd12) $display("FAIL b2b_mul_lo got %h exp 0000000c", lo_o); else n_pass++;
    issue(OP_DIVU, 32'd100, 32'd7);
    n_total++; if (busy !== 1'b1) $display("FAIL b2b_accept got %b exp 1", busy); else n_pass++;
    wait_done(n);
    n_total++; if (n !== 33) $display("FAIL b2b_latency got %0d exp 33", n); else n_pass++;
    n_total++; if (lo_o !== 32'd14) $display("FAIL b2b_quo got %h exp 0000000e", lo_o); else n_pass++;
    n_total++; if (hi_o !== 32'd2) $display("FAIL b2b_rem got %h exp 00000002", hi_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_move();
    test_mult_signed();
    test_mult_unsigned();
    test_div();
    test_div_zero();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
